coin_input_conditioner: RTL and testbench
=========================================

Name: coin_input_conditioner

Overview:
Front-end stage directly upstream of the vending-machine state register/FSM.
- Takes three asynchronous, bouncy coin-slot sensor lines and synchronizes and debounces each one.
- Converts each clean rising edge into a single-cycle coin event carrying the coin value, which the vending FSM consumes.
- Built from flip-flop chains plus per-line debounce counters.

Parameters:
SYNC_STAGES, 2, flip-flops per line in the synchronizer chain (>=2)
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed to accept a level change (>=1)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
coin_raw  input  3  raw sensor lines: bit0 = 5-cent, bit1 = 10-cent, bit2 = 25-cent; asynchronous to clk
coin_valid  output  1  one-cycle pulse: exactly one coin accepted this cycle
coin_value  output  5  value in cents of the accepted coin; 0 whenever coin_valid = 0
coin_err  output  1  one-cycle pulse: two or more lines produced an accepted rising edge in the same cycle

Behaviour:
- Reset (asynchronous, active-high):
  - All synchronizer flops, debounce counters and stable-level registers clear to 0.
  - coin_valid, coin_value and coin_err read 0 immediately, without waiting for a clock edge.
- Synchronizer: SYNC_STAGES-deep DFF chain per line; its last stage is the "synced" level.
- Debounce, per line i:
  - Holds a stable level s[i] and a counter cnt[i] of width clog2(DEBOUNCE_CYCLES+1).
  - Each edge where synced != s[i]: cnt[i] increments.
  - When that increment reaches DEBOUNCE_CYCLES: s[i] <= synced and cnt[i] <= 0 on the same edge.
  - Each edge where synced == s[i]: cnt[i] <= 0, so any bounce restarts the count.
  - The counter never exceeds DEBOUNCE_CYCLES and never wraps.
- Edge detect: rise[i] = s[i] transitions 0->1 on this edge. Falling transitions of s[i] generate nothing.
- Output register, updated every edge:
  - Exactly one rise[i]: coin_valid = 1, coin_value = value of line i (5/10/25), coin_err = 0.
  - Two or more rise[i]: coin_err = 1, coin_valid = 0, coin_value = 0. The coins are rejected, not queued.
  - No rise: all three outputs = 0.
  - All outputs are high for exactly one cycle per event.
- Latency:
  - raw line goes high before edge 0 and stays high: coin_valid is asserted after edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - Default parameters: asserted after edge 6, deasserted after edge 7.
- Holding a line high indefinitely yields one pulse. A new pulse requires s[i] to return to 0, which needs DEBOUNCE_CYCLES stable low samples.
- Pulses shorter than DEBOUNCE_CYCLES synchronized cycles are ignored entirely.
- Reset mid-debounce discards all partial counts. A line still high at reset release is treated as a new coin and is accepted after full latency.
- Lines are independent: one line debouncing never delays or blocks another. The only coupling is same-cycle collision to coin_err.
- No combinational path from coin_raw to any output.

Decomposition:
- Package vending_pkg holds:
  - NUM_COINS = 3
  - COIN_W = 5
  - COIN_5 = 5, COIN_10 = 10, COIN_25 = 25
  - Bit-index constants for the coin lines, shared with the vending FSM and change logic.
- Sub-module sync_debounce (clk, rst, raw, stable, rise; parameters SYNC_STAGES, DEBOUNCE_CYCLES), instantiated once per line.
- Top level does collision detection, value encoding and output registers only.

Test Plan:
1. rst = 1 for 3 cycles with coin_raw = 3'b111 -> coin_valid = coin_err = 0 and coin_value = 0 throughout; asserting rst mid-cycle drives outputs to 0 before the next clk edge.
2. Clean press: coin_raw = 3'b010 held 12 cycles -> exactly one coin_valid pulse, 6 edges after first sampling, with coin_value = 10; no coin_err.
3. Bounce: bit0 toggles 1,0,1,0,1,0 on consecutive cycles, then is held 1 -> no pulse during the toggling; one pulse with coin_value = 5 exactly 6 edges after the final rise.
4. Glitch: bit2 high for 3 cycles, then low -> no coin_valid, no coin_err; repeated 5 times -> still no pulse.
5. Collision: coin_raw 3'b000 -> 3'b101 on the same cycle, held -> one coin_err pulse, coin_valid = 0. Staggered by 2 cycles instead -> two coin_valid pulses (5 then 25) two cycles apart, no coin_err.
6. Reset mid-debounce: press bit1, assert rst 3 cycles later for 2 cycles while bit1 stays high -> no pulse from the pre-reset press; one pulse with coin_value = 10 six edges after rst deasserts.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared coin constants for the coin front end, vending FSM and change logic.
package vending_pkg;

  localparam int unsigned NUM_COINS = 3;
  localparam int unsigned COIN_W    = 5;

  localparam logic [COIN_W-1:0] COIN_5  = 5'd5;
  localparam logic [COIN_W-1:0] COIN_10 = 5'd10;
  localparam logic [COIN_W-1:0] COIN_25 = 5'd25;

  localparam int unsigned COIN_IDX_5  = 0;
  localparam int unsigned COIN_IDX_10 = 1;
  localparam int unsigned COIN_IDX_25 = 2;

  // Cent value carried by a given sensor line.
  function automatic logic [COIN_W-1:0] coin_cents(input int unsigned idx);
    logic [COIN_W-1:0] cents;
    cents = '0;
    case (idx)
      COIN_IDX_5:  cents = COIN_5;
      COIN_IDX_10: cents = COIN_10;
      COIN_IDX_25: cents = COIN_25;
      default:     cents = '0;
    endcase
    return cents;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// One coin sensor line: metastability synchronizer, stable-level debounce
// counter and registered rising-edge strobe.
module sync_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   stable_q, stable_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rise_q, rise_d;

  assign synced = sync_q[SYNC_STAGES-1];

  // Any sample that agrees with the stable level restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (synced != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// Coin-slot front end: per-line conditioning, then one registered coin event
// per cycle, or a collision flag when several coins land together.
module coin_input_conditioner
  import vending_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_COINS-1:0] coin_raw,
  output logic                 coin_valid,
  output logic [COIN_W-1:0]    coin_value,
  output logic                 coin_err
);

  logic [NUM_COINS-1:0] rise;
  logic [NUM_COINS-1:0] stable_unused;
  logic                 multi;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [COIN_W-1:0]    value_q, value_d;

  for (genvar g = 0; g < NUM_COINS; g++) begin : g_line
    sync_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_line (
      .clk    (clk),
      .rst    (rst),
      .raw    (coin_raw[g]),
      .stable (stable_unused[g]),
      .rise   (rise[g])
    );
  end

  // Collisions are rejected outright rather than queued.
  always_comb begin
    multi   = |(rise & (rise - NUM_COINS'(1)));
    valid_d = (rise != '0) && !multi;
    err_d   = multi;
    value_d = '0;
    if (valid_d) begin
      for (int unsigned i = 0; i < NUM_COINS; i++) begin
        if (rise[i]) value_d = value_d | coin_cents(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      value_q <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      value_q <= value_d;
    end
  end

  assign coin_valid = valid_q;
  assign coin_err   = err_q;
  assign coin_value = value_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Bench for coin_input_conditioner: vector table, corner-case sequences and
// random traffic against a sample-history reference model.
module tb_coin_input_conditioner;

  localparam int S = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] coin_raw = 3'b000;
  logic       coin_valid;
  logic [4:0] coin_value;
  logic       coin_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  coin_input_conditioner #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coin_raw   (coin_raw),
    .coin_valid (coin_valid),
    .coin_value (coin_value),
    .coin_err   (coin_err)
  );

  // Reference model: raw sample history and synced sample history.
  logic [2:0] m_rawq[$];
  logic [2:0] m_hist[$];
  logic [2:0] m_s;
  logic [2:0] m_rise;
  int         e_valid, e_err, e_value;

  function automatic int value_of(input logic [2:0] r);
    int v;
    v = 0;
    if (r[0]) v += 5;
    if (r[1]) v += 10;
    if (r[2]) v += 25;
    return v;
  endfunction

  task automatic model_reset();
    m_rawq.delete();
    m_hist.delete();
    m_s = 3'b000;
    m_rise = 3'b000;
    e_valid = 0; e_err = 0; e_value = 0;
  endtask

  task automatic model_edge(input logic [2:0] raw);
    logic [2:0] synced;
    logic [2:0] rise;
    int n;
    bit all_diff;
    n = $countones(m_rise);
    e_valid = (n == 1) ? 1 : 0;
    e_err   = (n > 1) ? 1 : 0;
    e_value = (n == 1) ? value_of(m_rise) : 0;
    synced = (m_rawq.size() >= S) ? m_rawq[m_rawq.size() - S] : 3'b000;
    m_rawq.push_back(raw);
    if (m_rawq.size() > S) void'(m_rawq.pop_front());
    m_hist.push_back(synced);
    if (m_hist.size() > D) void'(m_hist.pop_front());
    rise = 3'b000;
    for (int i = 0; i < 3; i++) begin
      all_diff = (m_hist.size() >= D);
      for (int k = 0; k < D; k++) begin
        if (all_diff && (m_hist[m_hist.size() - 1 - k][i] == m_s[i])) all_diff = 0;
      end
      if (all_diff) begin
        m_s[i] = ~m_s[i];
        if (m_s[i]) rise[i] = 1'b1;
      end
    end
    m_rise = rise;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive on the falling edge, advance the model on the rising edge,
  // compare just after it.
  task automatic tick(input logic [2:0] raw, input logic r);
    @(negedge clk);
    coin_raw = raw;
    rst = r;
    if (r) model_reset();
    @(posedge clk);
    if (r) model_reset();
    else model_edge(raw);
    #1;
    check("model_valid", int'(coin_valid), e_valid);
    check("model_value", int'(coin_value), e_value);
    check("model_err", int'(coin_err), e_err);
  endtask

  typedef struct {
    logic [2:0] raw;
    int hold;
    int n_valid;
    int n_err;
    int value;
    int at;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int nv, ne, val, at;
    int p_at[$];
    int p_val[$];
    logic [2:0] lvl;
    int left[3];

    vecs[0] = '{3'b010, 12, 1, 0, 10, 6};
    vecs[1] = '{3'b001, 12, 1, 0, 5, 6};
    vecs[2] = '{3'b100, 12, 1, 0, 25, 6};
    vecs[3] = '{3'b100, 3, 0, 0, 0, -1};
    vecs[4] = '{3'b101, 12, 0, 1, 0, 6};
    vecs[5] = '{3'b111, 12, 0, 1, 0, 6};
    vecs[6] = '{3'b011, 4, 0, 1, 0, 6};
    vecs[7] = '{3'b010, 4, 1, 0, 10, 6};

    model_reset();

    // Reset held with all lines high: outputs stay low.
    for (int t = 0; t < 3; t++) begin
      tick(3'b111, 1'b1);
      check("rst_valid", int'(coin_valid), 0);
      check("rst_err", int'(coin_err), 0);
    end
    for (int t = 0; t < 8; t++) tick(3'b000, 1'b0);

    // Vector table.
    foreach (vecs[v]) begin
      nv = 0; ne = 0; val = 0; at = -1;
      for (int t = 0; t < vecs[v].hold + 14; t++) begin
        tick((t < vecs[v].hold) ? vecs[v].raw : 3'b000, 1'b0);
        if (coin_valid) begin nv++; val = int'(coin_value); if (at < 0) at = t; end
        if (coin_err) begin ne++; if (at < 0) at = t; end
      end
      check($sformatf("vec%0d_nvalid", v), nv, vecs[v].n_valid);
      check($sformatf("vec%0d_nerr", v), ne, vecs[v].n_err);
      check($sformatf("vec%0d_value", v), val, vecs[v].value);
      check($sformatf("vec%0d_at", v), at, vecs[v].at);
    end

    // Repeated 3-cycle glitches on the 25-cent line.
    nv = 0; ne = 0;
    for (int r = 0; r < 5; r++) begin
      for (int t = 0; t < 6; t++) begin
        tick((t < 3) ? 3'b100 : 3'b000, 1'b0);
        nv += int'(coin_valid); ne += int'(coin_err);
      end
    end
    for (int t = 0; t < 10; t++) begin
      tick(3'b000, 1'b0);
      nv += int'(coin_valid); ne += int'(coin_err);
    end
    check("glitch_nvalid", nv, 0);
    check("glitch_nerr", ne, 0);

    // Bouncing 5-cent line, then held.
    nv = 0; val = 0; at = -1;
    for (int t = 0; t < 30; t++) begin
      if (t < 6) lvl = (t % 2 == 0) ? 3'b001 : 3'b000;
      else if (t < 20) lvl = 3'b001;
      else lvl = 3'b000;
      tick(lvl, 1'b0);
      if (coin_valid) begin nv++; val = int'(coin_value); if (at < 0) at = t; end
    end
    check("bounce_nvalid", nv, 1);
    check("bounce_value", val, 5);
    check("bounce_at", at, 12);

    // Staggered 5 then 25 two cycles apart.
    p_at.delete(); p_val.delete(); ne = 0;
    for (int t = 0; t < 26; t++) begin
      if (t < 2) lvl = 3'b001;
      else if (t < 14) lvl = 3'b101;
      else lvl = 3'b000;
      tick(lvl, 1'b0);
      if (coin_valid) begin p_at.push_back(t); p_val.push_back(int'(coin_value)); end
      ne += int'(coin_err);
    end
    check("stagger_npulse", p_at.size(), 2);
    check("stagger_nerr", ne, 0);
    if (p_at.size() == 2) begin
      check("stagger_at0", p_at[0], 6);
      check("stagger_val0", p_val[0], 5);
      check("stagger_at1", p_at[1], 8);
      check("stagger_val1", p_val[1], 25);
    end

    // Reset asserted mid-cycle while a pulse is showing.
    for (int t = 0; t < 7; t++) tick(3'b001, 1'b0);
    check("pre_async_valid", int'(coin_valid), 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_valid", int'(coin_valid), 0);
    check("async_value", int'(coin_value), 0);
    check("async_err", int'(coin_err), 0);
    tick(3'b000, 1'b1);
    for (int t = 0; t < 10; t++) tick(3'b000, 1'b0);

    // Reset in the middle of a 10-cent debounce.
    nv = 0;
    for (int t = 0; t < 3; t++) begin
      tick(3'b010, 1'b0);
      nv += int'(coin_valid);
    end
    for (int t = 0; t < 2; t++) begin
      tick(3'b010, 1'b1);
      nv += int'(coin_valid);
    end
    check("rstmid_pre_nvalid", nv, 0);
    nv = 0; val = 0; at = -1;
    for (int t = 0; t < 24; t++) begin
      tick((t < 12) ? 3'b010 : 3'b000, 1'b0);
      if (coin_valid) begin nv++; val = int'(coin_value); if (at < 0) at = t; end
    end
    check("rstmid_nvalid", nv, 1);
    check("rstmid_value", val, 10);
    check("rstmid_at", at, 6);

    // Random traffic with independent per-line hold times and rare resets.
    lvl = 3'b000;
    for (int i = 0; i < 3; i++) left[i] = 0;
    for (int t = 0; t < 2000; t++) begin
      for (int i = 0; i < 3; i++) begin
        if (left[i] == 0) begin
          lvl[i] = $urandom_range(0, 1) != 0;
          left[i] = $urandom_range(1, 8);
        end
        left[i]--;
      end
      tick(lvl, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end
    for (int t = 0; t < 12; t++) tick(3'b000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
